// File: rtl/flash_reader.sv
// SPI serial-flash read responder: turns a bus read into one READ (0x03) transaction and returns a little-endian 32-bit word.
// Optional single-entry read cache is enabled with `define FLASH_CACHE_EN.
module flash_reader #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        flash_clk,
    output logic        flash_csn,
    output logic        flash_io0_out,
    output logic        flash_io0_en,
    input  logic        flash_io1_in,
    output logic        flash_io1_out,
    output logic        flash_io1_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] CMD_READ = 8'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [63:0]      shift_r, shift_s;
    logic [31:0]      rx_r, rx_s;
    logic [31:0]      data_r, data_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [5:0]       bit_r, bit_s;
    logic             sclk_r, sclk_s;
    logic             csn_r, csn_s;
    logic             io0_en_r, io0_en_s;
    logic             ready_r, ready_s;
    logic             read_req_s;
    logic             write_ack_s;
    logic             start_s;
    logic             fill_s;
    logic             cache_hit_s;
    logic             unused_s;

    // Flash bytes arrive b0 first; the bus word is {b3,b2,b1,b0}.
    function automatic logic [31:0] byte_swap(input logic [31:0] rx);
        byte_swap = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

`ifdef FLASH_CACHE_EN
    logic        cache_valid_r;
    logic [21:0] cache_tag_r;
    logic [31:0] cache_data_r;
    logic [21:0] pend_tag_r;

    // Cache entry: tag captured at transaction start, filled when the word completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid_r <= 1'b0;
            cache_tag_r   <= 22'd0;
            cache_data_r  <= 32'd0;
            pend_tag_r    <= 22'd0;
        end else begin
            if (start_s) begin
                pend_tag_r <= address_in[23:2];
            end
            if (fill_s) begin
                cache_valid_r <= 1'b1;
                cache_tag_r   <= pend_tag_r;
                cache_data_r  <= data_s;
            end
        end
    end
`endif

    assign read_req_s  = sel_in && read_in;
    assign write_ack_s = (state_r == IDLE) && sel_in && !read_in && (write_mask_in != 4'b0000);

    // Next-state and next-register values for the transaction sequencer.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        rx_s        = rx_r;
        data_s      = data_r;
        div_s       = div_r;
        bit_s       = bit_r;
        sclk_s      = sclk_r;
        csn_s       = csn_r;
        io0_en_s    = io0_en_r;
        ready_s     = 1'b0;
        start_s     = 1'b0;
        fill_s      = 1'b0;
        cache_hit_s = 1'b0;
`ifdef FLASH_CACHE_EN
        cache_hit_s = cache_valid_r && (cache_tag_r == address_in[23:2]);
`endif
        case (state_r)
            IDLE: begin
                if (read_req_s && cache_hit_s) begin
`ifdef FLASH_CACHE_EN
                    data_s  = cache_data_r;
`endif
                    state_s = DONE;
                    ready_s = 1'b1;
                end else if (read_req_s) begin
                    start_s  = 1'b1;
                    state_s  = SHIFT;
                    shift_s  = {CMD_READ, address_in[23:2], 2'b00, 32'h0000_0000};
                    rx_s     = 32'h0000_0000;
                    div_s    = '0;
                    bit_s    = 6'd0;
                    sclk_s   = 1'b0;
                    csn_s    = 1'b0;
                    io0_en_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (div_r != DIV_LAST) begin
                    div_s = div_r + DIV_W'(1);
                end else if (!sclk_r) begin
                    div_s  = '0;
                    sclk_s = 1'b1;
                    rx_s   = {rx_r[30:0], flash_io1_in};
                end else if (bit_r == 6'd63) begin
                    div_s    = '0;
                    sclk_s   = 1'b0;
                    state_s  = DONE;
                    csn_s    = 1'b1;
                    io0_en_s = 1'b0;
                    ready_s  = 1'b1;
                    data_s   = byte_swap(rx_r);
                    fill_s   = 1'b1;
                end else begin
                    div_s   = '0;
                    sclk_s  = 1'b0;
                    bit_s   = bit_r + 6'd1;
                    shift_s = {shift_r[62:0], 1'b0};
                    // Command and address occupy the first 32 bits; MOSI is released after them.
                    if (bit_r == 6'd31) begin
                        io0_en_s = 1'b0;
                    end else begin
                        io0_en_s = io0_en_r;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s  = IDLE;
                csn_s    = 1'b1;
                sclk_s   = 1'b0;
                io0_en_s = 1'b0;
            end
        endcase
    end

    // Sequencer state register; reset parks the SPI lines with csn high and clock low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            shift_r  <= 64'd0;
            rx_r     <= 32'd0;
            data_r   <= 32'd0;
            div_r    <= '0;
            bit_r    <= 6'd0;
            sclk_r   <= 1'b0;
            csn_r    <= 1'b1;
            io0_en_r <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            rx_r     <= rx_s;
            data_r   <= data_s;
            div_r    <= div_s;
            bit_r    <= bit_s;
            sclk_r   <= sclk_s;
            csn_r    <= csn_s;
            io0_en_r <= io0_en_s;
            ready_r  <= ready_s;
        end
    end

    // Writes are acknowledged immediately so the CPU never stalls on this block.
    assign ready_out      = ready_r | write_ack_s;
    assign read_value_out = (sel_in && ready_r) ? data_r : 32'h0000_0000;
    assign flash_clk      = sclk_r;
    assign flash_csn      = csn_r;
    assign flash_io0_out  = shift_r[63];
    assign flash_io0_en   = io0_en_r;
    assign flash_io1_out  = 1'b0;
    assign flash_io1_en   = 1'b0;
    assign unused_s       = &{1'b0, write_value_in, address_in[31:24], address_in[1:0]};

endmodule

// File: tb/tb_flash_reader.sv
// Directed bench for flash_reader: two instances (CLK_DIV=1 and CLK_DIV=3) each with a small SPI flash model.
module tb_flash_reader;

    localparam logic [31:0] FLASH_WORD = 32'h1122_3344;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = 32'd0;
    logic        rd = 1'b0;
    logic [3:0]  wmask = 4'd0;
    logic [31:0] wdata = 32'hDEAD_BEEF;
    logic        sel [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        fclk [2];
    logic        fcsn [2];
    logic        mosi [2];
    logic        mosi_en [2];
    logic        miso [2];
    logic        io1_out [2];
    logic        io1_en [2];
    int          total_rise [2];
    int          base_rise [2];
    logic [31:0] cmd_cap [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        flash_reader #(.CLK_DIV(g == 0 ? 1 : 3)) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .address_in     (address),
            .sel_in         (sel[g]),
            .read_in        (rd),
            .read_value_out (rdata[g]),
            .write_mask_in  (wmask),
            .write_value_in (wdata),
            .ready_out      (ready[g]),
            .flash_clk      (fclk[g]),
            .flash_csn      (fcsn[g]),
            .flash_io0_out  (mosi[g]),
            .flash_io0_en   (mosi_en[g]),
            .flash_io1_in   (miso[g]),
            .flash_io1_out  (io1_out[g]),
            .flash_io1_en   (io1_en[g])
        );

        initial begin
            total_rise[g] = 0;
            base_rise[g]  = 0;
            cmd_cap[g]    = 32'd0;
            miso[g]       = 1'b0;
        end

        always @(posedge fclk[g]) begin
            total_rise[g] = total_rise[g] + 1;
            if (total_rise[g] - base_rise[g] <= 32) cmd_cap[g] = {cmd_cap[g][30:0], mosi[g]};
        end

        always @(negedge fcsn[g]) base_rise[g] = total_rise[g];

        // Mode 0 flash: data bits change after each falling edge once the address is in.
        always @(negedge fclk[g]) begin
            int idx;
            idx = total_rise[g] - base_rise[g];
            if (idx >= 32 && idx < 64) miso[g] = FLASH_WORD[63 - idx];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_read(input int w, input logic [31:0] addr, input int exp_lat,
                           input logic [31:0] exp_cmd, input logic [31:0] exp_data,
                           input bit exp_spi, input string tag);
        int n;
        int r0;
        @(negedge clk);
        address = addr;
        rd      = 1'b1;
        wmask   = 4'd0;
        sel[w]  = 1'b1;
        r0      = total_rise[w];
        @(posedge clk);
        n = 1;
        #1;
        while (!ready[w] && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_data"}, rdata[w], exp_data);
        check_eq({tag, "_csn_done"}, {31'd0, fcsn[w]}, 32'd1);
        check_eq({tag, "_clk_done"}, {31'd0, fclk[w]}, 32'd0);
        if (exp_spi) begin
            check_eq({tag, "_rises"}, 32'(total_rise[w] - r0), 32'd64);
            check_eq({tag, "_cmd"}, cmd_cap[w], exp_cmd);
        end else begin
            check_eq({tag, "_no_rises"}, 32'(total_rise[w] - r0), 32'd0);
        end
        rd     = 1'b0;
        sel[w] = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, "_ready_pulse"}, {31'd0, ready[w]}, 32'd0);
    endtask

    initial begin
        int n;
        int r0;
        sel[0] = 1'b1;
        sel[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_csn", {31'd0, fcsn[0]}, 32'd1);
        check_eq("rst_clk", {31'd0, fclk[0]}, 32'd0);
        check_eq("rst_ready", {31'd0, ready[0]}, 32'd0);
        check_eq("rst_rdata", rdata[0], 32'd0);
        check_eq("rst_csn_div3", {31'd0, fcsn[1]}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        sel[0]  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("idle_no_edges", 32'(total_rise[0] + total_rise[1]), 32'd0);
        check_eq("idle_csn", {31'd0, fcsn[0]}, 32'd1);
        check_eq("io1_const", {30'd0, io1_out[0], io1_en[0]}, 32'd0);

        do_read(0, 32'h0000_0104, 129, 32'h0300_0104, 32'h4433_2211, 1'b1, "div1");

        // Write is acknowledged combinationally with no SPI activity.
        @(negedge clk);
        r0      = total_rise[0];
        address = 32'h0000_0200;
        wmask   = 4'b1111;
        rd      = 1'b0;
        sel[0]  = 1'b1;
        #1;
        check_eq("wr_ready", {31'd0, ready[0]}, 32'd1);
        check_eq("wr_rdata", rdata[0], 32'd0);
        @(posedge clk);
        #1;
        check_eq("wr_csn", {31'd0, fcsn[0]}, 32'd1);
        sel[0] = 1'b0;
        wmask  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("wr_no_edges", 32'(total_rise[0] - r0), 32'd0);

        do_read(1, 32'h0000_0107, 385, 32'h0300_0104, 32'h4433_2211, 1'b1, "div3");

        // Reset in the middle of the address phase.
        @(negedge clk);
        address = 32'h0000_0204;
        rd      = 1'b1;
        sel[0]  = 1'b1;
        r0      = total_rise[0];
        n       = 0;
        while (total_rise[0] - r0 < 20 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check_eq("mid_reached_bit20", 32'(total_rise[0] - r0 >= 20), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_csn", {31'd0, fcsn[0]}, 32'd1);
        check_eq("mid_rst_clk", {31'd0, fclk[0]}, 32'd0);
        check_eq("mid_rst_en", {31'd0, mosi_en[0]}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, ready[0]}, 32'd0);
        rd     = 1'b0;
        sel[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        do_read(0, 32'h0000_0104, 129, 32'h0300_0104, 32'h4433_2211, 1'b1, "post_rst");
`ifdef FLASH_CACHE_EN
        do_read(0, 32'h0000_0104, 1, 32'h0300_0104, 32'h4433_2211, 1'b0, "cache_hit");
`else
        do_read(0, 32'h0000_0104, 129, 32'h0300_0104, 32'h4433_2211, 1'b1, "repeat_read");
`endif
        do_read(0, 32'h0000_0108, 129, 32'h0300_0108, 32'h4433_2211, 1'b1, "new_addr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
